// File: rtl/ret_addr_stack_pkg.sv
// Shared widths and stack-operation encoding for the return address stack.
package ret_addr_stack_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int RAS_DEPTH  = 8;

   typedef enum logic [1:0] {
      RASOP_NONE,
      RASOP_PUSH,
      RASOP_POP,
      RASOP_REPL
   } RasOp_t;

   // call and return together rewrite the top entry
   function automatic RasOp_t ras_decode(input logic call_, input logic return_);
      RasOp_t op;
      op = RASOP_NONE;
      if (!call_ && !return_) op = RASOP_REPL;
      else if (!call_)        op = RASOP_PUSH;
      else if (!return_)      op = RASOP_POP;
      return op;
   endfunction

endpackage

// File: rtl/ret_addr_stack_ras_core.sv
// One circular return-address stack with saturating count and whole-state load.
module ras_core
   import ret_addr_stack_pkg::*;
#(
   parameter int ADDR  = ADDR_WIDTH,
   parameter int DEPTH = RAS_DEPTH,
   parameter int PTR   = $clog2(DEPTH),
   parameter int BUS_W = DEPTH * ADDR + PTR + PTR + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  RasOp_t           op,
   input  logic [ADDR-1:0]  push_data,
   input  logic             load_en,
   input  logic [BUS_W-1:0] load_bus,
   output logic [BUS_W-1:0] nxt_bus,
   output logic [ADDR-1:0]  top,
   output logic             valid
);

   localparam logic [PTR:0] CNT_FULL = DEPTH[PTR:0];

   logic [ADDR-1:0] mem_q [DEPTH];
   logic [ADDR-1:0] mem_d [DEPTH];
   logic [PTR-1:0]  tp_q, tp_d, tp_inc;
   logic [PTR:0]    cnt_q, cnt_d;
   logic            do_push;

   always_comb begin
      mem_d   = mem_q;
      tp_d    = tp_q;
      cnt_d   = cnt_q;
      tp_inc  = tp_q + PTR'(1);
      do_push = (op == RASOP_PUSH) || (op == RASOP_REPL && cnt_q == '0);

      if (do_push) begin
         tp_d          = tp_inc;
         mem_d[tp_inc] = push_data;
         if (cnt_q != CNT_FULL) cnt_d = cnt_q + (PTR+1)'(1);
      end else if (op == RASOP_REPL) begin
         mem_d[tp_q] = push_data;
      end else if (op == RASOP_POP && cnt_q != '0) begin
         tp_d  = tp_q - PTR'(1);
         cnt_d = cnt_q - (PTR+1)'(1);
      end

      // load overrides the local op; bus layout is {cnt, tp, mem[DEPTH-1..0]}
      if (load_en) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = load_bus[i*ADDR +: ADDR];
         tp_d  = load_bus[DEPTH*ADDR +: PTR];
         cnt_d = load_bus[DEPTH*ADDR+PTR +: PTR+1];
      end

      nxt_bus = '0;
      for (int unsigned i = 0; i < DEPTH; i++) nxt_bus[i*ADDR +: ADDR] = mem_d[i];
      nxt_bus[DEPTH*ADDR +: PTR]       = tp_d;
      nxt_bus[DEPTH*ADDR+PTR +: PTR+1] = cnt_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         tp_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
      end
   end

   assign top   = mem_q[tp_q];
   assign valid = (cnt_q != '0);

endmodule

// File: rtl/ret_addr_stack.sv
// Speculative return address stack, rebuilt from a committed copy on flush.
module ret_addr_stack
   import ret_addr_stack_pkg::*;
#(
   parameter int ADDR  = ADDR_WIDTH,
   parameter int DEPTH = RAS_DEPTH,
   parameter int PTR   = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inst_e_,
   input  logic [ADDR-1:0] inst_pc,
   input  logic            inst_call_,
   input  logic            inst_return_,
   input  logic            jump_call_,
   input  logic            jump_return_,
   input  logic [ADDR-1:0] com_link_addr,
   input  logic            wb_flush_,
   output logic            ret_v,
   output logic [ADDR-1:0] ret_pc
);

   localparam int BUS_W = DEPTH * ADDR + PTR + PTR + 1;

   RasOp_t           s_op, c_op;
   logic [ADDR-1:0]  inst_link;
   logic [BUS_W-1:0] c_nxt_bus;
   logic [BUS_W-1:0] s_nxt_unused;
   logic [ADDR-1:0]  c_top_unused;
   logic             c_valid_unused;

   always_comb begin
      s_op = RASOP_NONE;
      if (!inst_e_ && wb_flush_) s_op = ras_decode(inst_call_, inst_return_);
      c_op      = ras_decode(jump_call_, jump_return_);
      inst_link = inst_pc + ADDR'(4);
   end

   ras_core #(.ADDR(ADDR), .DEPTH(DEPTH), .PTR(PTR), .BUS_W(BUS_W)) u_com (
      .clk       (clk),
      .reset     (reset),
      .op        (c_op),
      .push_data (com_link_addr),
      .load_en   (1'b0),
      .load_bus  ('0),
      .nxt_bus   (c_nxt_bus),
      .top       (c_top_unused),
      .valid     (c_valid_unused)
   );

   // loading C's next state lets a commit in the flush cycle reach S
   ras_core #(.ADDR(ADDR), .DEPTH(DEPTH), .PTR(PTR), .BUS_W(BUS_W)) u_spec (
      .clk       (clk),
      .reset     (reset),
      .op        (s_op),
      .push_data (inst_link),
      .load_en   (!wb_flush_),
      .load_bus  (c_nxt_bus),
      .nxt_bus   (s_nxt_unused),
      .top       (ret_pc),
      .valid     (ret_v)
   );

endmodule

// File: tb/tb_ret_addr_stack.sv
// Scoreboard bench: driver predicts from a queue-of-arrays stack model, monitor compares each cycle.
module tb_ret_addr_stack;

   localparam int A = 32;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         inst_e_ = 1'b1, inst_call_ = 1'b1, inst_return_ = 1'b1;
   logic [A-1:0] inst_pc = '0;
   logic         jump_call_ = 1'b1, jump_return_ = 1'b1;
   logic [A-1:0] com_link_addr = '0;
   logic         wb_flush_ = 1'b1;
   logic         ret_v;
   logic [A-1:0] ret_pc;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic         v;
      logic [A-1:0] pc;
   } exp_t;
   exp_t exp_q[$];

   // index 0 = speculative, 1 = committed
   logic [A-1:0] m_mem [2][D];
   int           m_tp  [2];
   int           m_cnt [2];

   always #5 clk = ~clk;

   ret_addr_stack #(.ADDR(A), .DEPTH(D)) dut (
      .clk           (clk),
      .reset         (reset),
      .inst_e_       (inst_e_),
      .inst_pc       (inst_pc),
      .inst_call_    (inst_call_),
      .inst_return_  (inst_return_),
      .jump_call_    (jump_call_),
      .jump_return_  (jump_return_),
      .com_link_addr (com_link_addr),
      .wb_flush_     (wb_flush_),
      .ret_v         (ret_v),
      .ret_pc        (ret_pc)
   );

   function automatic void m_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < D; i++) m_mem[k][i] = '0;
         m_tp[k]  = 0;
         m_cnt[k] = 0;
      end
   endfunction

   function automatic void m_push(int k, logic [A-1:0] d);
      m_tp[k] = (m_tp[k] + 1) % D;
      m_mem[k][m_tp[k]] = d;
      if (m_cnt[k] < D) m_cnt[k]++;
   endfunction

   function automatic void m_op(int k, logic cn, logic rn, logic [A-1:0] d);
      if (!cn && !rn) begin
         if (m_cnt[k] == 0) m_push(k, d);
         else m_mem[k][m_tp[k]] = d;
      end else if (!cn) begin
         m_push(k, d);
      end else if (!rn && m_cnt[k] > 0) begin
         m_tp[k] = (m_tp[k] + D - 1) % D;
         m_cnt[k]--;
      end
   endfunction

   task automatic step(input logic rst, input logic e_n, input logic cn, input logic rn,
                       input logic [A-1:0] pc, input logic jc, input logic jr,
                       input logic [A-1:0] link, input logic fl);
      exp_t e;
      @(negedge clk);
      reset = rst; inst_e_ = e_n; inst_call_ = cn; inst_return_ = rn; inst_pc = pc;
      jump_call_ = jc; jump_return_ = jr; com_link_addr = link; wb_flush_ = fl;
      if (rst) m_clear();
      else begin
         m_op(1, jc, jr, link);
         if (!fl) begin
            for (int i = 0; i < D; i++) m_mem[0][i] = m_mem[1][i];
            m_tp[0]  = m_tp[1];
            m_cnt[0] = m_cnt[1];
         end else if (!e_n) begin
            m_op(0, cn, rn, pc + 32'd4);
         end
      end
      e.v  = (m_cnt[0] != 0);
      e.pc = m_mem[0][m_tp[0]];
      exp_q.push_back(e);
   endtask

   task automatic fcall(input logic [A-1:0] pc);
      step(1'b0, 1'b0, 1'b0, 1'b1, pc, 1'b1, 1'b1, '0, 1'b1);
   endtask

   task automatic fret();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, '0, 1'b1);
   endtask

   task automatic frepl(input logic [A-1:0] pc);
      step(1'b0, 1'b0, 1'b0, 1'b0, pc, 1'b1, 1'b1, '0, 1'b1);
   endtask

   // direct check of constants taken from the test plan, just after the edge
   task automatic expect_now(input string name, input logic v, input logic [A-1:0] pc,
                             input bit chk_pc);
      @(posedge clk);
      #2;
      n_tests++;
      if (ret_v !== v || (chk_pc && ret_pc !== pc)) begin
         n_fail++;
         $display("FAIL %s: got ret_v=%0b ret_pc=%h, want ret_v=%0b ret_pc=%h",
                  name, ret_v, ret_pc, v, pc);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (ret_v !== e.v || ret_pc !== e.pc) begin
               n_fail++;
               $display("FAIL ret_out @%0t: got ret_v=%0b ret_pc=%h, want ret_v=%0b ret_pc=%h",
                        $time, ret_v, ret_pc, e.v, e.pc);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      m_clear();
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b1);
      expect_now("reset_state", 1'b0, 32'h0, 1'b1);

      // 1: basic push/pop
      fcall(32'h100);
      expect_now("call_0x100", 1'b1, 32'h104, 1'b1);
      fcall(32'h200);
      expect_now("call_0x200", 1'b1, 32'h204, 1'b1);
      fret();
      expect_now("ret_to_0x104", 1'b1, 32'h104, 1'b1);
      fret();
      expect_now("empty_after_pops", 1'b0, 32'h0, 1'b0);

      // 2: overflow drops the oldest entry, underflow is ignored
      for (int i = 0; i < 9; i++) fcall(32'h1000 + 32'h10 * i);
      expect_now("overflow_top", 1'b1, 32'h1084, 1'b1);
      for (int i = 0; i < 7; i++) fret();
      expect_now("seventh_pop", 1'b1, 32'h1014, 1'b1);
      fret();
      expect_now("eighth_pop_empty", 1'b0, 32'h0, 1'b0);
      fret();
      expect_now("underflow_pop", 1'b0, 32'h0, 1'b0);
      fcall(32'h40);
      expect_now("push_after_underflow", 1'b1, 32'h44, 1'b1);
      fret();

      // 3: flush restores committed copy
      step(1'b0, 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b1, 32'h304, 1'b1);
      fcall(32'h400);
      fcall(32'h500);
      step(1'b0, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b0);
      expect_now("flush_restore", 1'b1, 32'h304, 1'b1);

      // 4: commit + fetch + flush together
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h700, 1'b0, 1'b1, 32'h604, 1'b0);
      expect_now("flush_with_commit", 1'b1, 32'h604, 1'b1);
      fret();
      expect_now("flush_cnt_two", 1'b1, 32'h304, 1'b1);
      fret();
      expect_now("flush_cnt_empty", 1'b0, 32'h0, 1'b0);

      // 5: replace on populated and on empty stack
      fcall(32'h100);
      frepl(32'h800);
      expect_now("repl_top", 1'b1, 32'h804, 1'b1);
      fret();
      expect_now("repl_cnt_same", 1'b0, 32'h0, 1'b0);
      frepl(32'h800);
      expect_now("repl_empty_push", 1'b1, 32'h804, 1'b1);
      fret();

      // 6: asynchronous reset between edges
      fcall(32'h10);
      fcall(32'h20);
      fcall(32'h30);
      @(posedge clk);
      #2;
      reset = 1'b1;
      m_clear();
      #1;
      n_tests++;
      if (ret_v !== 1'b0 || ret_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got ret_v=%0b ret_pc=%h, want ret_v=0 ret_pc=0", ret_v, ret_pc);
      end
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b1);
      fcall(32'h900);
      expect_now("call_after_reset", 1'b1, 32'h904, 1'b1);

      // random mix checked by the monitor against the model
      for (int n = 0; n < 400; n++) begin
         step(1'b0,
              ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)),
              $urandom,
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 2) != 0),
              $urandom,
              ($urandom_range(0, 11) != 0));
      end

      step(1'b0, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b1, '0, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
